disp_bin2bcd: RTL and testbench

Sequential binary-to-BCD formatter feeding the four-digit seven-segment driver in the vending machine display path. Accepts a binary amount (credit, price or change) with a valid strobe, converts it serially by double-dabble, and holds four 4-bit digit codes (`val3`..`val0`) stable for the display multiplexer until the next request. Also produces the all-dash refund pattern, optional leading-zero blanking, and saturation with an overflow flag.

---
 rtl/disp_pkg.sv | 15 +
 rtl/disp_bin2bcd_if.sv | 25 ++
 rtl/bcd_digit_adj.sv | 7 +
 rtl/disp_bin2bcd.sv | 148 ++++++++++++++
 tb/tb_disp_bin2bcd.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared display constants and the converter FSM state type, also used by the
// seven-segment driver.
package disp_pkg;

    localparam logic [3:0]  DIGIT_DASH  = 4'd10;
    localparam logic [3:0]  DIGIT_BLANK = 4'd15;
    localparam int unsigned BCD_MAX     = 9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_e;

endpackage

// File: rtl/disp_bin2bcd_if.sv
// Request/result bundle between the amount source and the binary-to-BCD formatter.
interface disp_bin2bcd_if #(
    parameter int WIDTH = 14
);
    logic             valid_in;
    logic [WIDTH-1:0] bin_in;
    logic             dash_in;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       val3;
    logic [3:0]       val2;
    logic [3:0]       val1;
    logic [3:0]       val0;

    modport master (
        output valid_in, bin_in, dash_in,
        input  busy, done, ovf, val3, val2, val1, val0
    );

    modport slave (
        input  valid_in, bin_in, dash_in,
        output busy, done, ovf, val3, val2, val1, val0
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/disp_bin2bcd.sv
// Serial double-dabble formatter with saturation, dash pattern and held digit outputs.
// Optional leading-zero blanking is enabled by defining DISP_LZ_BLANK_EN.
module disp_bin2bcd
    import disp_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input logic           clk,
    input logic           rst_n,
    disp_bin2bcd_if.slave bus
);
    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [15:0]      DASH_WORD = {4{DIGIT_DASH}};
`ifdef DISP_LZ_BLANK_EN
    localparam logic [15:0] RESET_WORD = {DIGIT_BLANK, DIGIT_BLANK, DIGIT_BLANK, 4'd0};
`else
    localparam logic [15:0] RESET_WORD = 16'd0;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_ovf_q, pend_ovf_d;
    logic [15:0]      disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic             done_q;

    logic [15:0] acc_adj;
    logic [15:0] blanked;
    logic        unused_adj_msb;
    logic        in_ovf;
    logic        busy, start_num, start_dash, shifting, latching;

    for (genvar i = 0; i < 4; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (acc_q[4*i +: 4]),
            .d_o (acc_adj[4*i +: 4])
        );
    end
    // With saturated inputs the thousands nibble never reaches 8, so its MSB is lost on shift.
    assign unused_adj_msb = acc_adj[15];

    assign in_ovf = 32'(bus.bin_in) > BCD_MAX;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            pend_ovf_q <= 1'b0;
            disp_q     <= RESET_WORD;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            pend_ovf_q <= pend_ovf_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            done_q     <= latching;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.valid_in) state_d = bus.dash_in ? LATCH : SHIFT;
            SHIFT:   if (cnt_q == LAST_BIT) state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b1;
        start_num  = 1'b0;
        start_dash = 1'b0;
        shifting   = 1'b0;
        latching   = 1'b0;
        case (state_q)
            IDLE: begin
                busy       = 1'b0;
                start_num  = bus.valid_in & ~bus.dash_in;
                start_dash = bus.valid_in & bus.dash_in;
            end
            SHIFT:   shifting = 1'b1;
            LATCH:   latching = 1'b1;
            default: busy = 1'b0;
        endcase
    end

`ifdef DISP_LZ_BLANK_EN
    // Blank from the thousands digit down until the first non-zero digit; units always shown.
    always_comb begin
        blanked = acc_q;
        if (acc_q[15:12] == 4'd0) begin
            blanked[15:12] = DIGIT_BLANK;
            if (acc_q[11:8] == 4'd0) begin
                blanked[11:8] = DIGIT_BLANK;
                if (acc_q[7:4] == 4'd0) blanked[7:4] = DIGIT_BLANK;
            end
        end
    end
`else
    assign blanked = acc_q;
`endif

    always_comb begin
        sr_d       = sr_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        pend_ovf_d = pend_ovf_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        if (start_num) begin
            sr_d       = in_ovf ? WIDTH'(BCD_MAX) : bus.bin_in;
            acc_d      = '0;
            cnt_d      = '0;
            pend_ovf_d = in_ovf;
        end else if (start_dash) begin
            acc_d      = DASH_WORD;
            pend_ovf_d = 1'b0;
        end else if (shifting) begin
            sr_d  = sr_q << 1;
            acc_d = {acc_adj[14:0], sr_q[WIDTH-1]};
            cnt_d = cnt_q + CNT_W'(1);
        end else if (latching) begin
            disp_d = blanked;
            ovf_d  = pend_ovf_q;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.val3 = disp_q[15:12];
    assign bus.val2 = disp_q[11:8];
    assign bus.val1 = disp_q[7:4];
    assign bus.val0 = disp_q[3:0];

endmodule

// File: tb/tb_disp_bin2bcd.sv
// Self-checking bench for disp_bin2bcd: directed corner cases plus random amounts
// compared against a decimal-arithmetic reference model.
module tb_disp_bin2bcd;
    localparam int WIDTH = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] exp_disp;
    logic        exp_ovf;
    logic [15:0] reset_word;

    disp_bin2bcd_if #(.WIDTH(WIDTH)) bus ();

    disp_bin2bcd #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] model_digits(int unsigned n);
        int unsigned v;
        logic [3:0]  d [4];
        bit          leading;
        v    = (n > 9999) ? 9999 : n;
        d[3] = 4'(v / 1000);
        d[2] = 4'((v / 100) % 10);
        d[1] = 4'((v / 10) % 10);
        d[0] = 4'(v % 10);
`ifdef DISP_LZ_BLANK_EN
        leading = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            if (leading && d[k] == 4'd0) d[k] = 4'd15;
            else leading = 1'b0;
        end
`else
        leading = 1'b0;
`endif
        return {d[3], d[2], d[1], d[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag);
        check({tag, ".val"}, {16'd0, bus.val3, bus.val2, bus.val1, bus.val0}, {16'd0, exp_disp});
        check({tag, ".ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
    endtask

    // Issue one request at the next edge and follow it cycle by cycle to completion.
    task automatic convert(input int unsigned n, input bit dash);
        int lat;
        bus.valid_in = 1'b1;
        bus.bin_in   = WIDTH'(n);
        bus.dash_in  = dash;
        step();
        bus.valid_in = 1'b0;
        bus.dash_in  = 1'b0;
        lat = dash ? 0 : WIDTH;
        for (int c = 0; c <= lat; c++) begin
            check("busy_during", {31'd0, bus.busy}, 32'd1);
            check("done_during", {31'd0, bus.done}, 32'd0);
            check_disp("hold");
            step();
        end
        exp_disp = dash ? 16'hAAAA : model_digits(n);
        exp_ovf  = !dash && (n > 9999);
        check("done_pulse", {31'd0, bus.done}, 32'd1);
        check("busy_end", {31'd0, bus.busy}, 32'd0);
        check_disp("result");
    endtask

    initial begin
`ifdef DISP_LZ_BLANK_EN
        reset_word = 16'hFFF0;
`else
        reset_word = 16'h0000;
`endif
        bus.valid_in = 1'b0;
        bus.bin_in   = '0;
        bus.dash_in  = 1'b0;
        exp_disp     = reset_word;
        exp_ovf      = 1'b0;

        step();
        step();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check_disp("rst");
        rst_n = 1'b1;
        step();

        convert(1234, 1'b0);
        step();
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        convert(9999, 1'b0);
        convert(12000, 1'b0);
        convert(7, 1'b0);
        convert(0, 1'b0);
        convert(5678, 1'b1);
        convert(16383, 1'b0);
        convert(10000, 1'b0);
        convert(10, 1'b0);
        convert(100, 1'b0);
        convert(1000, 1'b0);
        convert(305, 1'b0);

        // A request raised mid-conversion must be dropped, not queued.
        step();
        bus.valid_in = 1'b1;
        bus.bin_in   = WIDTH'(42);
        step();
        bus.valid_in = 1'b0;
        for (int c = 1; c <= 4; c++) step();
        bus.valid_in = 1'b1;
        bus.bin_in   = WIDTH'(9000);
        bus.dash_in  = 1'b1;
        step();
        bus.valid_in = 1'b0;
        bus.dash_in  = 1'b0;
        for (int c = 6; c <= WIDTH + 1; c++) begin
            check("ign_hold", {16'd0, bus.val3, bus.val2, bus.val1, bus.val0}, {16'd0, exp_disp});
            step();
        end
        exp_disp = model_digits(42);
        exp_ovf  = 1'b0;
        check("ign_done", {31'd0, bus.done}, 32'd1);
        check_disp("ign_result");
        for (int c = 0; c < 4; c++) begin
            step();
            check("ign_no_queue_busy", {31'd0, bus.busy}, 32'd0);
            check("ign_no_queue_done", {31'd0, bus.done}, 32'd0);
        end
        convert(8086, 1'b0);

        for (int r = 0; r < 20; r++) begin
            int unsigned n;
            bit          d;
            n = $urandom_range(0, 16383);
            d = ($urandom_range(0, 7) == 0);
            convert(n, d);
        end

        // Reset in the middle of a conversion discards it without a done pulse.
        step();
        bus.valid_in = 1'b1;
        bus.bin_in   = WIDTH'(5555);
        step();
        bus.valid_in = 1'b0;
        for (int c = 1; c <= 6; c++) step();
        rst_n = 1'b0;
        step();
        exp_disp = reset_word;
        exp_ovf  = 1'b0;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check_disp("midrst");
        rst_n = 1'b1;
        for (int c = 0; c < WIDTH + 2; c++) begin
            step();
            check("midrst_no_done", {31'd0, bus.done}, 32'd0);
            check_disp("midrst_hold");
        end
        convert(4321, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
